// File: rtl/panda_risc_v_sb_pkg.sv
// Shared constants for the long-instruction scoreboard: register file size,
// release-port indices and the outstanding-counter width.
package panda_risc_v_sb_pkg;

  localparam int REG_N      = 32;
  localparam int REG_ID_W   = 5;
  localparam int OUTS_CNT_W = 4;

  localparam int RLS_N   = 3;
  localparam int RLS_LSU = 0;
  localparam int RLS_MUL = 1;
  localparam int RLS_DIV = 2;

endpackage

// File: rtl/panda_risc_v_sb_outs_cnt.sv
// Saturating outstanding-instruction counter: +1 per launch, -1 per release.
// Over/underflow saturates the count and raises err for that cycle.
module panda_risc_v_sb_outs_cnt
  import panda_risc_v_sb_pkg::*;
#(
  parameter int OUTS_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch,
  input  logic [RLS_N-1:0]      rls,
  output logic [OUTS_CNT_W-1:0] cnt,
  output logic                  full,
  output logic                  idle,
  output logic                  err
);

  localparam logic [OUTS_CNT_W+1:0] MAX_W = (OUTS_CNT_W+2)'(OUTS_MAX);

  logic [OUTS_CNT_W+1:0] up;
  logic [OUTS_CNT_W+1:0] dn;
  logic [OUTS_CNT_W+1:0] diff;
  logic [OUTS_CNT_W-1:0] cnt_nxt;

  always_comb begin
    dn = '0;
    for (int i = 0; i < RLS_N; i++) begin
      dn = dn + {{(OUTS_CNT_W+1){1'b0}}, rls[i]};
    end
    up      = {2'b00, cnt} + {{(OUTS_CNT_W+1){1'b0}}, launch};
    diff    = up - dn;
    err     = 1'b0;
    cnt_nxt = diff[OUTS_CNT_W-1:0];
    if (up < dn) begin
      cnt_nxt = '0;
      err     = 1'b1;
    end else if (diff > MAX_W) begin
      cnt_nxt = MAX_W[OUTS_CNT_W-1:0];
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  assign full = (cnt == MAX_W[OUTS_CNT_W-1:0]);
  assign idle = (cnt == '0);

endmodule

// File: rtl/panda_risc_v_long_inst_scoreboard.sv
// Pending-write bitmap for in-flight long instructions; answers WAW/RAW
// dependency queries from dispatch and reports outstanding/full/idle status.
module panda_risc_v_long_inst_scoreboard
  import panda_risc_v_sb_pkg::*;
#(
  parameter int    OUTS_MAX      = 4,
  parameter string EN_REL_BYPASS = "true"
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [REG_ID_W-1:0]   waw_dpc_check_rd_id,
  output logic                  rd_waw_dpc,
  input  logic [REG_ID_W-1:0]   raw_dpc_check_rs1_id,
  output logic                  rs1_raw_dpc,
  input  logic [REG_ID_W-1:0]   raw_dpc_check_rs2_id,
  output logic                  rs2_raw_dpc,
  input  logic                  launch_valid,
  input  logic [REG_ID_W-1:0]   launch_rd_id,
  input  logic                  launch_rd_vld,
  input  logic                  lsu_rls_valid,
  input  logic [REG_ID_W-1:0]   lsu_rls_rd_id,
  input  logic                  lsu_rls_rd_vld,
  input  logic                  mul_rls_valid,
  input  logic [REG_ID_W-1:0]   mul_rls_rd_id,
  input  logic                  div_rls_valid,
  input  logic [REG_ID_W-1:0]   div_rls_rd_id,
  output logic                  outs_full,
  output logic                  outs_idle,
  output logic [OUTS_CNT_W-1:0] outs_cnt,
  output logic                  sb_err
);

  localparam bit BYPASS = (EN_REL_BYPASS == "true");

  logic [REG_N-1:0] pend;
  logic [REG_N-1:0] pend_nxt;
  logic [REG_N-1:0] clr_vec;
  logic [REG_N-1:0] set_vec;
  logic             err;

  logic launch_set, launch_acc;
  logic lsu_clr, mul_clr, div_clr;
  logic lsu_bad, mul_bad, div_bad;
  logic lsu_ok, mul_ok, div_ok;
  logic dup, cnt_err;
  logic [RLS_N-1:0] rls_eff;

  assign launch_set = launch_valid & launch_rd_vld & (launch_rd_id != '0);

  assign lsu_clr = lsu_rls_valid & lsu_rls_rd_vld & (lsu_rls_rd_id != '0);
  assign mul_clr = mul_rls_valid & (mul_rls_rd_id != '0);
  assign div_clr = div_rls_valid & (div_rls_rd_id != '0);

  // A release is bogus only if its RD is neither pending nor being launched now.
  assign lsu_bad = lsu_clr & ~pend[lsu_rls_rd_id] & ~(launch_set & (launch_rd_id == lsu_rls_rd_id));
  assign mul_bad = mul_clr & ~pend[mul_rls_rd_id] & ~(launch_set & (launch_rd_id == mul_rls_rd_id));
  assign div_bad = div_clr & ~pend[div_rls_rd_id] & ~(launch_set & (launch_rd_id == div_rls_rd_id));

  assign lsu_ok = lsu_clr & ~lsu_bad;
  assign mul_ok = mul_clr & ~mul_bad;
  assign div_ok = div_clr & ~div_bad;

  always_comb begin
    rls_eff          = '0;
    rls_eff[RLS_LSU] = lsu_rls_valid & ~lsu_bad;
    rls_eff[RLS_MUL] = mul_rls_valid & ~mul_bad;
    rls_eff[RLS_DIV] = div_rls_valid & ~div_bad;
  end

  assign launch_acc = launch_valid & ~(outs_full & ~(|rls_eff));

  assign dup = (lsu_ok & mul_ok & (lsu_rls_rd_id == mul_rls_rd_id)) |
               (lsu_ok & div_ok & (lsu_rls_rd_id == div_rls_rd_id)) |
               (mul_ok & div_ok & (mul_rls_rd_id == div_rls_rd_id));

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (lsu_ok) clr_vec[lsu_rls_rd_id] = 1'b1;
    if (mul_ok) clr_vec[mul_rls_rd_id] = 1'b1;
    if (div_ok) clr_vec[div_rls_rd_id] = 1'b1;
    if (launch_acc && launch_set) set_vec[launch_rd_id] = 1'b1;
    pend_nxt = (pend & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      pend <= {pend_nxt[REG_N-1:1], 1'b0};
      err  <= err | cnt_err | lsu_bad | mul_bad | div_bad | dup;
    end
  end

  panda_risc_v_sb_outs_cnt #(.OUTS_MAX(OUTS_MAX)) u_outs_cnt (
    .clk    (clk),
    .rst_n  (resetn),
    .launch (launch_valid),
    .rls    (rls_eff),
    .cnt    (outs_cnt),
    .full   (outs_full),
    .idle   (outs_idle),
    .err    (cnt_err)
  );

  // Bit 0 of pend is held at zero, so x0 queries always miss.
  assign rd_waw_dpc  = pend[waw_dpc_check_rd_id]  & ~(BYPASS & clr_vec[waw_dpc_check_rd_id]);
  assign rs1_raw_dpc = pend[raw_dpc_check_rs1_id] & ~(BYPASS & clr_vec[raw_dpc_check_rs1_id]);
  assign rs2_raw_dpc = pend[raw_dpc_check_rs2_id] & ~(BYPASS & clr_vec[raw_dpc_check_rs2_id]);
  assign sb_err      = err;

endmodule

// File: tb/tb_panda_risc_v_long_inst_scoreboard.sv
// Directed bench for the long-instruction scoreboard: expectations are queued
// as stimulus is driven, then popped and compared against the DUT outputs.
module tb_panda_risc_v_long_inst_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] waw_id, rs1_id, rs2_id;
  logic       launch_valid, launch_rd_vld;
  logic [4:0] launch_rd_id;
  logic       lsu_valid, lsu_rd_vld, mul_valid, div_valid;
  logic [4:0] lsu_rd_id, mul_rd_id, div_rd_id;

  logic       waw, rs1, rs2, full, idle, err;
  logic [3:0] cnt;
  logic       nb_waw, nb_rs1, nb_rs2, nb_full, nb_idle, nb_err;
  logic [3:0] nb_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  panda_risc_v_long_inst_scoreboard #(.OUTS_MAX(4), .EN_REL_BYPASS("true")) dut (
    .clk(clk), .resetn(resetn),
    .waw_dpc_check_rd_id(waw_id), .rd_waw_dpc(waw),
    .raw_dpc_check_rs1_id(rs1_id), .rs1_raw_dpc(rs1),
    .raw_dpc_check_rs2_id(rs2_id), .rs2_raw_dpc(rs2),
    .launch_valid(launch_valid), .launch_rd_id(launch_rd_id), .launch_rd_vld(launch_rd_vld),
    .lsu_rls_valid(lsu_valid), .lsu_rls_rd_id(lsu_rd_id), .lsu_rls_rd_vld(lsu_rd_vld),
    .mul_rls_valid(mul_valid), .mul_rls_rd_id(mul_rd_id),
    .div_rls_valid(div_valid), .div_rls_rd_id(div_rd_id),
    .outs_full(full), .outs_idle(idle), .outs_cnt(cnt), .sb_err(err)
  );

  panda_risc_v_long_inst_scoreboard #(.OUTS_MAX(4), .EN_REL_BYPASS("false")) dut_nb (
    .clk(clk), .resetn(resetn),
    .waw_dpc_check_rd_id(waw_id), .rd_waw_dpc(nb_waw),
    .raw_dpc_check_rs1_id(rs1_id), .rs1_raw_dpc(nb_rs1),
    .raw_dpc_check_rs2_id(rs2_id), .rs2_raw_dpc(nb_rs2),
    .launch_valid(launch_valid), .launch_rd_id(launch_rd_id), .launch_rd_vld(launch_rd_vld),
    .lsu_rls_valid(lsu_valid), .lsu_rls_rd_id(lsu_rd_id), .lsu_rls_rd_vld(lsu_rd_vld),
    .mul_rls_valid(mul_valid), .mul_rls_rd_id(mul_rd_id),
    .div_rls_valid(div_valid), .div_rls_rd_id(div_rd_id),
    .outs_full(nb_full), .outs_idle(nb_idle), .outs_cnt(nb_cnt), .sb_err(nb_err)
  );

  task automatic push(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [3:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty observed=%0d expected=<queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) begin
        passed++;
      end else begin
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle_in();
    launch_valid = 0; launch_rd_vld = 0; launch_rd_id = 0;
    lsu_valid = 0; lsu_rd_vld = 0; lsu_rd_id = 0;
    mul_valid = 0; mul_rd_id = 0; div_valid = 0; div_rd_id = 0;
    waw_id = 0; rs1_id = 0; rs2_id = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] rd, input logic vld);
    launch_valid = 1; launch_rd_id = rd; launch_rd_vld = vld;
  endtask

  initial begin
    idle_in();
    resetn = 0;
    tick(); tick();
    waw_id = 5;
    #1;
    push("rst_idle", 1); pop_check({3'b0, idle});
    push("rst_full", 0); pop_check({3'b0, full});
    push("rst_cnt", 0);  pop_check(cnt);
    push("rst_err", 0);  pop_check({3'b0, err});
    push("rst_waw", 0);  pop_check({3'b0, waw});
    resetn = 1;
    tick();

    // basic launch / mul release
    launch(5, 1); tick(); idle_in();
    waw_id = 5; #1;
    push("l5_waw", 1);  pop_check({3'b0, waw});
    push("l5_cnt", 1);  pop_check(cnt);
    push("l5_idle", 0); pop_check({3'b0, idle});
    mul_valid = 1; mul_rd_id = 5; #1;
    push("mul5_byp_waw", 0);   pop_check({3'b0, waw});
    push("mul5_nobyp_waw", 1); pop_check({3'b0, nb_waw});
    tick(); idle_in(); waw_id = 5; #1;
    push("mul5_after_waw", 0);    pop_check({3'b0, waw});
    push("mul5_after_nb_waw", 0); pop_check({3'b0, nb_waw});
    push("mul5_after_idle", 1);   pop_check({3'b0, idle});

    // store with no RD
    launch(8, 0); tick(); idle_in(); waw_id = 8; #1;
    push("st_waw", 0); pop_check({3'b0, waw});
    push("st_cnt", 1); pop_check(cnt);
    lsu_valid = 1; lsu_rd_id = 8; lsu_rd_vld = 0; tick(); idle_in(); #1;
    push("st_rls_cnt", 0); pop_check(cnt);
    push("st_rls_err", 0); pop_check({3'b0, err});

    // same-cycle release bypass
    launch(7, 1); tick(); idle_in();
    div_valid = 1; div_rd_id = 7; rs1_id = 7; #1;
    push("byp_rs1_true", 0);  pop_check({3'b0, rs1});
    push("byp_rs1_false", 1); pop_check({3'b0, nb_rs1});
    tick(); idle_in(); rs1_id = 7; #1;
    push("byp_after_rs1", 0);    pop_check({3'b0, rs1});
    push("byp_after_nb_rs1", 0); pop_check({3'b0, nb_rs1});

    // fill to OUTS_MAX, then launch with release while full, then overflow
    for (int i = 1; i <= 4; i++) begin
      launch(5'(i), 1); tick();
    end
    idle_in(); #1;
    push("fill_full", 1); pop_check({3'b0, full});
    push("fill_cnt", 4);  pop_check(cnt);
    launch(10, 1); lsu_valid = 1; lsu_rd_id = 1; lsu_rd_vld = 1;
    tick(); idle_in(); rs1_id = 1; rs2_id = 10; #1;
    push("full_rl_cnt", 4); pop_check(cnt);
    push("full_rl_err", 0); pop_check({3'b0, err});
    push("full_rl_rs1", 0); pop_check({3'b0, rs1});
    push("full_rl_rs2", 1); pop_check({3'b0, rs2});
    launch(11, 1); tick(); idle_in(); waw_id = 11; rs2_id = 10; #1;
    push("ovf_err", 1); pop_check({3'b0, err});
    push("ovf_cnt", 4); pop_check(cnt);
    push("ovf_waw", 0); pop_check({3'b0, waw});

    // asynchronous reset mid-run
    resetn = 0; #1;
    push("arst_cnt", 0);  pop_check(cnt);
    push("arst_full", 0); pop_check({3'b0, full});
    push("arst_idle", 1); pop_check({3'b0, idle});
    push("arst_err", 0);  pop_check({3'b0, err});
    push("arst_rs2", 0);  pop_check({3'b0, rs2});
    tick(); resetn = 1; tick();

    // triple release with simultaneous launch
    launch(3, 1); tick(); launch(4, 1); tick(); launch(6, 1); tick(); idle_in();
    launch(9, 1);
    lsu_valid = 1; lsu_rd_id = 3; lsu_rd_vld = 1;
    mul_valid = 1; mul_rd_id = 4;
    div_valid = 1; div_rd_id = 6;
    tick(); idle_in();
    rs1_id = 3; rs2_id = 4; waw_id = 6; #1;
    push("tri_cnt", 1);   pop_check(cnt);
    push("tri_rs1_3", 0); pop_check({3'b0, rs1});
    push("tri_rs2_4", 0); pop_check({3'b0, rs2});
    push("tri_waw_6", 0); pop_check({3'b0, waw});
    push("tri_err", 0);   pop_check({3'b0, err});
    waw_id = 9; #1;
    push("tri_waw_9", 1); pop_check({3'b0, waw});
    lsu_valid = 1; lsu_rd_id = 9; lsu_rd_vld = 1; tick(); idle_in();

    // x0 launch and spurious release
    launch(0, 1); tick(); idle_in(); waw_id = 0; #1;
    push("x0_waw", 0); pop_check({3'b0, waw});
    push("x0_cnt", 1); pop_check(cnt);
    mul_valid = 1; mul_rd_id = 12; tick(); idle_in(); #1;
    push("bad_rls_err", 1); pop_check({3'b0, err});
    push("bad_rls_cnt", 1); pop_check(cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
